// File: rtl/mem_model_mp_pkg.sv
// rtl/mem_model_mp_pkg.sv - shared types for the multi-port memory responder
package mem_model_pkg;

    typedef enum logic [1:0] {
        PS_IDLE = 2'd0,
        PS_WAIT = 2'd1,
        PS_RESP = 2'd2
    } port_state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } mem_op_t;

endpackage

// File: rtl/mem_model_mp_arbiter.sv
// rtl/mem_model_mp_arbiter.sv - round-robin one-hot arbiter with rotating pointer
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0]  ptr;
    logic [N-1:0]   rot_req;
    logic [N-1:0]   rot_gnt;
    logic [2*N-1:0] gnt2;
    logic           found;
    int             off;
    int             nxt;

    // Rotate requests so the pointer sits at bit 0, pick the lowest, rotate back.
    always_comb begin
        rot_req = N'({req, req} >> ptr);
        rot_gnt = '0;
        found   = 1'b0;
        off     = 0;
        for (int i = 0; i < N; i++) begin
            if (!found && rot_req[i]) begin
                rot_gnt[i] = 1'b1;
                found      = 1'b1;
                off        = i;
            end
        end
        gnt2  = {{N{1'b0}}, rot_gnt} << ptr;
        grant = gnt2[N-1:0] | gnt2[2*N-1:N];
        nxt   = int'(ptr) + off + 1;
        if (nxt >= N) begin
            nxt = nxt - N;
        end
    end

    // Pointer moves to the port after the winner; holds when nobody asks.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= '0;
        end else if (advance && found) begin
            ptr <= PW'(nxt);
        end
    end

endmodule

// File: rtl/mem_model_mp.sv
// rtl/mem_model_mp.sv - multi-port, latency-configurable data-memory responder
module mem_model_mp #(
    parameter int ADDR_BITS   = 8,
    parameter int DATA_BITS   = 16,
    parameter int NUM_PORTS   = 4,
    parameter int LATENCY     = 2,
    parameter int INIT_BASE   = 7,
    parameter int INIT_STRIDE = 3
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NUM_PORTS-1:0]           mem_read_valid,
    input  logic [NUM_PORTS*ADDR_BITS-1:0] mem_read_address,
    output logic [NUM_PORTS-1:0]           mem_read_ready,
    output logic [NUM_PORTS*DATA_BITS-1:0] mem_read_data,
    input  logic [NUM_PORTS-1:0]           mem_write_valid,
    input  logic [NUM_PORTS*ADDR_BITS-1:0] mem_write_address,
    input  logic [NUM_PORTS*DATA_BITS-1:0] mem_write_data,
    output logic [NUM_PORTS-1:0]           mem_write_ready,
    output logic [NUM_PORTS-1:0]           port_busy
);
    import mem_model_pkg::*;

    localparam int DEPTH = 2 ** ADDR_BITS;
    localparam int CW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    // Words are stored as the difference from the preload pattern, so a
    // zero power-up state reads back as the INIT pattern and no reset or
    // load sequence is needed to establish it.
    logic [DATA_BITS-1:0] mem_q [DEPTH];

    logic [NUM_PORTS-1:0] req;
    logic [NUM_PORTS-1:0] grant;
    logic                 gnt_any;
    logic                 gnt_write;
    logic [ADDR_BITS-1:0] gnt_addr;
    logic [DATA_BITS-1:0] gnt_wdata;
    logic [DATA_BITS-1:0] arr_rdata;

    function automatic logic [DATA_BITS-1:0] init_word(input logic [ADDR_BITS-1:0] a);
        logic [31:0] v;
        v = 32'(a) * 32'(INIT_STRIDE) + 32'(INIT_BASE);
        return v[DATA_BITS-1:0];
    endfunction

    rr_arbiter #(.N(NUM_PORTS)) u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .advance (gnt_any),
        .grant   (grant)
    );

    assign gnt_any = |grant;

    // Select the single granted port's access; a write wins over a read on the same port.
    always_comb begin
        gnt_write = 1'b0;
        gnt_addr  = '0;
        gnt_wdata = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (grant[p]) begin
                gnt_write = mem_write_valid[p];
                gnt_addr  = mem_write_valid[p] ? mem_write_address[p*ADDR_BITS +: ADDR_BITS]
                                               : mem_read_address[p*ADDR_BITS +: ADDR_BITS];
                gnt_wdata = mem_write_data[p*DATA_BITS +: DATA_BITS];
            end
        end
    end

    assign arr_rdata = mem_q[gnt_addr] ^ init_word(gnt_addr);

    // Granted write commits on the grant edge; reset suppresses new commits.
    always_ff @(posedge clk) begin
        if (reset_n && gnt_any && gnt_write) begin
            mem_q[gnt_addr] <= gnt_wdata ^ init_word(gnt_addr);
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        port_state_t          state;
        mem_op_t              op;
        logic [CW-1:0]        cnt;
        logic [DATA_BITS-1:0] rd_buf;
        logic [DATA_BITS-1:0] rdata;

        assign req[p] = (state == PS_IDLE) && (mem_read_valid[p] || mem_write_valid[p]);

        // Per-port IDLE -> WAIT -> RESP sequence with grant-to-ready countdown.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state  <= PS_IDLE;
                op     <= OP_READ;
                cnt    <= '0;
                rd_buf <= '0;
                rdata  <= '0;
            end else begin
                case (state)
                    PS_IDLE: begin
                        if (grant[p]) begin
                            op     <= mem_write_valid[p] ? OP_WRITE : OP_READ;
                            rd_buf <= arr_rdata;
                            cnt    <= CW'(LATENCY - 1);
                            if (LATENCY == 1) begin
                                state <= PS_RESP;
                                if (!mem_write_valid[p]) begin
                                    rdata <= arr_rdata;
                                end
                            end else begin
                                state <= PS_WAIT;
                            end
                        end
                    end
                    PS_WAIT: begin
                        cnt <= cnt - 1'b1;
                        if (cnt == CW'(1)) begin
                            state <= PS_RESP;
                            if (op == OP_READ) begin
                                rdata <= rd_buf;
                            end
                        end
                    end
                    PS_RESP: state <= PS_IDLE;
                    default: state <= PS_IDLE;
                endcase
            end
        end

        assign mem_read_ready[p]                           = (state == PS_RESP) && (op == OP_READ);
        assign mem_write_ready[p]                          = (state == PS_RESP) && (op == OP_WRITE);
        assign port_busy[p]                                = (state != PS_IDLE);
        assign mem_read_data[p*DATA_BITS +: DATA_BITS]     = rdata;
    end

endmodule
